exe_seq_ctrl: RTL and testbench
===============================

Name: exe_seq_ctrl

Overview:
Execute-stage sequencer that sits between decode and the shared execute datapath (operand muxes plus ALU). It accepts one decoded op at a time over a valid/ready handshake and drives the ALU op code and the operand selects. Non-branch ops take one ALU pass; the result is held for writeback under backpressure. Branch ops reuse the single ALU for two passes: a compare (rs1 vs rs2) and, only if taken, a target add (pc + imm). The outcome is reported as a one-cycle redirect pulse.

Parameters:
XLEN, 64, datapath width (matches REG_BUS)
ALUOP_CMP, 4'b0001, aluop driven for branch compare pass (subtract/compare)
ALUOP_ADD, 4'b0000, aluop driven for branch target pass and in idle states

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low
flush  in  1  synchronous abort of in-flight op
in_valid  in  1  decoded op available
in_ready  out  1  sequencer accepts op this cycle
in_aluop  in  4  ALU op for non-branch op
in_op1_sel  in  1  1=rs1, 0=pc for non-branch op
in_op2_sel  in  1  1=rs2, 0=imm for non-branch op
in_is_branch  in  1  op is conditional branch
in_br_type  in  2  00 BEQ, 01 BNE, 10 BLT, 11 BGE
alu_aluop  out  4  to ALU
alu_op1_sel  out  1  to execute operand-1 mux
alu_op2_sel  out  1  to execute operand-2 mux
alu_result  in  XLEN  ALU result, combinational from current controls
alu_eq  in  1  ALU equal flag
alu_less  in  1  ALU signed-less flag
out_valid  out  1  result valid to writeback
out_ready  in  1  writeback accepts result
out_data  out  XLEN  registered result
br_valid  out  1  one-cycle branch-resolved pulse
br_taken  out  1  branch outcome, valid with br_valid
br_target  out  XLEN  pc+imm, valid with br_valid when br_taken=1

Behaviour:
- The block assumes rs1/rs2/imm/pc at the datapath stay stable from accept until the op retires. Upstream holds them.
- Reset (rst=0, async): state=IDLE. All of the following are 0: out_valid, out_data, br_valid, br_taken, br_target, and the captured op registers.
- States: IDLE, EXEC, OUT, BR_CMP, BR_TGT.
- in_ready = !flush & (state==IDLE | (state==OUT & out_ready)). A handshake fires when in_valid & in_ready.
- Handshake: capture aluop, op1_sel, op2_sel, is_branch and br_type. Next state is BR_CMP if is_branch, else EXEC.
- EXEC:
  - Controls = captured aluop and sels.
  - At the edge, out_data <= alu_result and out_valid <= 1. Next state OUT.
- OUT:
  - out_valid=1; out_data is held stable while out_ready=0.
  - On out_ready: if a new handshake fires, go to EXEC or BR_CMP with out_valid dropping to 0; otherwise go to IDLE with out_valid=0.
  - Throughput is one non-branch op per 2 cycles; latency is accept -> out_valid = 2 edges.
- BR_CMP:
  - Controls = ALUOP_CMP, op1_sel=1, op2_sel=1.
  - taken = alu_eq (BEQ), !alu_eq (BNE), alu_less (BLT), !alu_less (BGE).
  - If taken: register br_taken=1 and go to BR_TGT.
  - Else: br_valid=1 and br_taken=0 next cycle, go to IDLE. br_target is unchanged.
- BR_TGT:
  - Controls = ALUOP_ADD, op1_sel=0, op2_sel=0.
  - At the edge: br_target <= alu_result, br_valid <= 1, br_taken stays 1. Next state IDLE.
- br_valid is high for exactly one cycle; it is registered and cleared the following cycle. Branches never assert out_valid.
- In IDLE and OUT, controls = ALUOP_ADD, op1_sel=1, op2_sel=1.
- flush (synchronous, highest priority):
  - Next state = IDLE; out_valid, br_valid and br_taken go to 0. out_data and br_target keep their values.
  - in_ready=0 during the flush cycle, so no handshake occurs.
  - A result in OUT is discarded even if out_ready=1 in the same cycle.
- Reset asserted mid-op: immediate return to reset values; no pulse is emitted.
- Widths: all data paths are XLEN. The block performs no arithmetic itself; all arithmetic is in the ALU.

Test Plan:
- Reset then non-branch: aluop=4'b0000, sels=1/1, stub alu_result=64'h15 -> alu_aluop=0 in EXEC, out_valid=1 at edge 2 with out_data=64'h15, IDLE after out_ready.
- Backpressure: out_ready=0 for 3 cycles in OUT while alu_result changes to 64'hFF -> out_data stays 64'h15, in_ready=0; out_ready=1 with in_valid=1 -> accept same cycle, out_valid=0 next cycle.
- BEQ taken: alu_eq=1 in BR_CMP, alu_result=64'h8000_0010 in BR_TGT -> controls CMP/1/1 then ADD/0/0; br_valid single pulse, br_taken=1, br_target=64'h8000_0010; out_valid never 1.
- BLT not taken: alu_less=0 -> br_valid pulse one cycle after BR_CMP, br_taken=0, no BR_TGT cycle; also BNE with alu_eq=0 -> taken, BGE with alu_less=0 -> taken.
- Flush: assert flush in BR_CMP -> no br_valid, state IDLE next cycle; flush in OUT with out_ready=1 and in_valid=1 -> in_ready=0, out_valid=0 next cycle.
- Async reset: drop rst mid-cycle in BR_TGT -> outputs zero immediately without clock edge; release, op accepted normally on next in_valid.

Source files
------------

// File: rtl/exe_seq_ctrl.sv
// -----------------------------------------------------------------------------
// exe_seq_ctrl
//   Execute-stage sequencer between decode and the shared execute datapath
//   (operand muxes + ALU). Accepts one decoded op at a time and drives the ALU
//   op code and operand selects.
//   Non-branch ops take one ALU pass. The result is registered and held for
//   writeback under backpressure.
//   Branch ops use two passes. The first is a compare (rs1 vs rs2). The second
//   is a target add (pc + imm) and runs only when the branch is taken. The
//   outcome is reported as a one-cycle br_valid pulse.
//
// Handshakes (valid/ready): a transfer happens on a rising edge where both
//   valid and ready are 1. A producer holds valid and its payload stable until
//   that transfer. in_ready never depends combinationally on in_valid.
//   out_valid/out_data stay stable until out_ready is seen.
//
// Ports
//   clk, rst (async, active-low), flush (sync abort, highest priority)
//   in_valid/in_ready, in_aluop, in_op1_sel, in_op2_sel, in_is_branch,
//   in_br_type                              : decoded op from decode
//   alu_aluop, alu_op1_sel, alu_op2_sel     : controls to the execute datapath
//   alu_result, alu_eq, alu_less            : combinational ALU outputs
//   out_valid/out_ready, out_data           : non-branch result to writeback
//   br_valid, br_taken, br_target           : branch resolution
//   state_dbg                               : current FSM state for checkers
// -----------------------------------------------------------------------------
module exe_seq_ctrl #(
  parameter int          XLEN      = 64,
  parameter logic [3:0]  ALUOP_CMP = 4'b0001,
  parameter logic [3:0]  ALUOP_ADD = 4'b0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_aluop,
  input  logic            in_op1_sel,
  input  logic            in_op2_sel,
  input  logic            in_is_branch,
  input  logic [1:0]      in_br_type,
  output logic [3:0]      alu_aluop,
  output logic            alu_op1_sel,
  output logic            alu_op2_sel,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_eq,
  input  logic            alu_less,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            br_valid,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target,
  output logic [2:0]      state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EXEC   = 3'd1,
    OUT    = 3'd2,
    BR_CMP = 3'd3,
    BR_TGT = 3'd4
  } state_t;

  localparam logic [1:0] BR_BEQ = 2'b00;
  localparam logic [1:0] BR_BNE = 2'b01;
  localparam logic [1:0] BR_BLT = 2'b10;

  state_t state, state_nxt;

  // Captured op. is_branch is not kept separately: the branch/non-branch
  // choice is already encoded by which state path the FSM takes.
  logic [3:0] op_aluop;
  logic       op_op1_sel;
  logic       op_op2_sel;
  logic [1:0] op_br_type;

  logic fire;
  logic br_cond;

  assign state_dbg = state;

  // A new op can enter only from IDLE, or from OUT in the same cycle the
  // held result leaves. Flush blocks any handshake in its cycle.
  assign in_ready = !flush && ((state == IDLE) || ((state == OUT) && out_ready));
  assign fire     = in_valid && in_ready;

  // Branch condition, evaluated from the ALU flags during the compare pass.
  always_comb begin
    br_cond = 1'b0;
    case (op_br_type)
      BR_BEQ:  br_cond = alu_eq;
      BR_BNE:  br_cond = !alu_eq;
      BR_BLT:  br_cond = alu_less;
      default: br_cond = !alu_less;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next state and datapath controls
  always_comb begin
    state_nxt   = state;
    alu_aluop   = ALUOP_ADD;
    alu_op1_sel = 1'b1;
    alu_op2_sel = 1'b1;
    case (state)
      IDLE: begin
        if (fire) state_nxt = in_is_branch ? BR_CMP : EXEC;
      end
      EXEC: begin
        alu_aluop   = op_aluop;
        alu_op1_sel = op_op1_sel;
        alu_op2_sel = op_op2_sel;
        state_nxt   = OUT;
      end
      OUT: begin
        if (out_ready) begin
          if (fire) state_nxt = in_is_branch ? BR_CMP : EXEC;
          else      state_nxt = IDLE;
        end
      end
      BR_CMP: begin
        alu_aluop   = ALUOP_CMP;
        alu_op1_sel = 1'b1;
        alu_op2_sel = 1'b1;
        state_nxt   = br_cond ? BR_TGT : IDLE;
      end
      BR_TGT: begin
        // Second pass: pc + imm gives the branch target.
        alu_aluop   = ALUOP_ADD;
        alu_op1_sel = 1'b0;
        alu_op2_sel = 1'b0;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Captured op and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_aluop   <= '0;
      op_op1_sel <= 1'b0;
      op_op2_sel <= 1'b0;
      op_br_type <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      br_valid   <= 1'b0;
      br_taken   <= 1'b0;
      br_target  <= '0;
    end else begin
      // br_valid is a pulse. It is cleared every cycle unless set below.
      br_valid <= 1'b0;
      if (fire) begin
        op_aluop   <= in_aluop;
        op_op1_sel <= in_op1_sel;
        op_op2_sel <= in_op2_sel;
        op_br_type <= in_br_type;
      end
      if (flush) begin
        // Flush drops pending results. out_data and br_target keep their values.
        out_valid <= 1'b0;
        br_taken  <= 1'b0;
      end else begin
        case (state)
          EXEC: begin
            out_valid <= 1'b1;
            out_data  <= alu_result;
          end
          OUT: begin
            if (out_ready) out_valid <= 1'b0;
          end
          BR_CMP: begin
            br_taken <= br_cond;
            // Not taken: resolve now. Taken: resolve after the target pass.
            if (!br_cond) br_valid <= 1'b1;
          end
          BR_TGT: begin
            br_target <= alu_result;
            br_valid  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exe_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exe_seq_ctrl
//   Bench for exe_seq_ctrl. A behavioural ALU stub computes alu_result and the
//   flags from the operand registers rs1/rs2/pc/imm. The bench derives the
//   expected values directly from the ops it issues:
//     - a non-branch result is aluop applied to the selected operands
//     - a branch outcome comes from the rs1/rs2 relation
//     - a branch target is pc + imm
// -----------------------------------------------------------------------------
module tb_exe_seq_ctrl;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_aluop;
  logic            in_op1_sel;
  logic            in_op2_sel;
  logic            in_is_branch;
  logic [1:0]      in_br_type;
  logic [3:0]      alu_aluop;
  logic            alu_op1_sel;
  logic            alu_op2_sel;
  logic [XLEN-1:0] alu_result;
  logic            alu_eq;
  logic            alu_less;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic            br_valid;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic [2:0]      state_dbg;

  // Datapath operands, held by the bench while an op is in flight.
  logic [XLEN-1:0] rs1, rs2, pc, imm;
  logic [XLEN-1:0] op_a, op_b;
  logic [XLEN-1:0] exp_target;

  int n_checks;
  int n_fail;

  exe_seq_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_op1_sel(in_op1_sel), .in_op2_sel(in_op2_sel),
    .in_is_branch(in_is_branch), .in_br_type(in_br_type),
    .alu_aluop(alu_aluop), .alu_op1_sel(alu_op1_sel), .alu_op2_sel(alu_op2_sel),
    .alu_result(alu_result), .alu_eq(alu_eq), .alu_less(alu_less),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference functions ----------------
  function automatic logic [XLEN-1:0] alu_f(input logic [3:0] op,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    case (op)
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic br_outcome(input logic [1:0] t,
                                      input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
    case (t)
      2'b00:   return a == b;
      2'b01:   return a != b;
      2'b10:   return $signed(a) < $signed(b);
      default: return $signed(a) >= $signed(b);
    endcase
  endfunction

  // ALU stub: combinational from the current controls
  always_comb begin
    op_a       = alu_op1_sel ? rs1 : pc;
    op_b       = alu_op2_sel ? rs2 : imm;
    alu_result = alu_f(alu_aluop, op_a, op_b);
    alu_eq     = (op_a == op_b);
    alu_less   = $signed(op_a) < $signed(op_b);
  end

  // ---------------- driver / scenario tasks ----------------
  // All tasks start and end at a falling clock edge.

  task automatic drive_op(input logic is_br, input logic [1:0] bt,
                          input logic [3:0] aop, input logic s1, input logic s2);
    in_valid     = 1'b1;
    in_is_branch = is_br;
    in_br_type   = bt;
    in_aluop     = aop;
    in_op1_sel   = s1;
    in_op2_sel   = s2;
  endtask

  // Issue one op from IDLE and follow it to completion.
  task automatic run_op(input logic is_br, input logic [1:0] bt,
                        input logic [3:0] aop, input logic s1, input logic s2,
                        input int stall);
    logic [XLEN-1:0] exp_d;
    logic            exp_tk;
    exp_d  = alu_f(aop, s1 ? rs1 : pc, s2 ? rs2 : imm);
    exp_tk = br_outcome(bt, rs1, rs2);
    drive_op(is_br, bt, aop, s1, s2);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %b need 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    if (!is_br) begin
      n_checks++; if ({alu_aluop, alu_op1_sel, alu_op2_sel} !== {aop, s1, s2}) begin
        n_fail++; $display("FAIL exec_ctrl: got %h/%b/%b need %h/%b/%b", alu_aluop, alu_op1_sel, alu_op2_sel, aop, s1, s2); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL exec_out_valid: got %b need 0", out_valid); end
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || out_data !== exp_d) begin
        n_fail++; $display("FAIL out_result: got v=%b d=%h need v=1 d=%h", out_valid, out_data, exp_d); end
      for (int i = 0; i < stall; i++) begin
        in_valid = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b need 0", in_ready); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_data !== exp_d) begin
          n_fail++; $display("FAIL stall_hold: got v=%b d=%h need v=1 d=%h", out_valid, out_data, exp_d); end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL retire: got v=%b rdy=%b need v=0 rdy=1", out_valid, in_ready); end
    end else begin
      n_checks++; if ({alu_aluop, alu_op1_sel, alu_op2_sel} !== {4'b0001, 1'b1, 1'b1}) begin
        n_fail++; $display("FAIL cmp_ctrl: got %h/%b/%b need 1/1/1", alu_aluop, alu_op1_sel, alu_op2_sel); end
      @(negedge clk);
      if (exp_tk) begin
        #1;
        n_checks++; if ({alu_aluop, alu_op1_sel, alu_op2_sel, br_valid} !== {4'b0000, 1'b0, 1'b0, 1'b0}) begin
          n_fail++; $display("FAIL tgt_ctrl: got %h/%b/%b bv=%b need 0/0/0 bv=0", alu_aluop, alu_op1_sel, alu_op2_sel, br_valid); end
        exp_target = pc + imm;
        @(negedge clk);
      end
      n_checks++; if (br_valid !== 1'b1 || br_taken !== exp_tk || br_target !== exp_target || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL br_resolve: got bv=%b tk=%b tgt=%h ov=%b need bv=1 tk=%b tgt=%h ov=0",
                           br_valid, br_taken, br_target, out_valid, exp_tk, exp_target); end
      @(negedge clk);
      n_checks++; if (br_valid !== 1'b0) begin n_fail++; $display("FAIL br_pulse_width: got %b need 0", br_valid); end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_aluop = '0; in_op1_sel = 1'b0; in_op2_sel = 1'b0; in_is_branch = 1'b0; in_br_type = '0;
    rs1 = '0; rs2 = '0; pc = '0; imm = '0; exp_target = '0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if ({out_valid, br_valid, br_taken} !== 3'b000 || out_data !== '0 || br_target !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got ov=%b bv=%b tk=%b d=%h tgt=%h need zeros", out_valid, br_valid, br_taken, out_data, br_target); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({in_ready, alu_aluop, alu_op1_sel, alu_op2_sel} !== {1'b1, 4'b0000, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL reset_idle: got rdy=%b %h/%b/%b need rdy=1 0/1/1", in_ready, alu_aluop, alu_op1_sel, alu_op2_sel); end
  endtask

  task automatic test_nonbranch;
    rs1 = 64'h10; rs2 = 64'h5; pc = 64'h0; imm = 64'h0;
    run_op(1'b0, 2'b00, 4'b0000, 1'b1, 1'b1, 0);
  endtask

  task automatic test_backpressure;
    rs1 = 64'h10; rs2 = 64'h5; pc = 64'h0; imm = 64'h0;
    drive_op(1'b0, 2'b00, 4'b0000, 1'b1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rs1 = 64'hFA;  // ALU output now reads 0xFF; the held result must not change
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b need 0", in_ready); end
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || out_data !== 64'h15) begin
        n_fail++; $display("FAIL bp_hold: got v=%b d=%h need v=1 d=15", out_valid, out_data); end
    end
    pc = 64'h1234; imm = 64'hF0;
    drive_op(1'b0, 2'b00, 4'd4, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept: got %b need 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || {alu_aluop, alu_op1_sel, alu_op2_sel} !== {4'd4, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL bp_next_exec: got v=%b %h/%b/%b need v=0 4/0/0", out_valid, alu_aluop, alu_op1_sel, alu_op2_sel); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_data !== (64'h1234 ^ 64'hF0)) begin
      n_fail++; $display("FAIL bp_second: got v=%b d=%h need v=1 d=%h", out_valid, out_data, 64'h1234 ^ 64'hF0); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    // Non-branch result leaves OUT in the same cycle a branch is accepted.
    rs1 = 64'h7; rs2 = 64'h9; pc = 64'h4000; imm = 64'h20;
    drive_op(1'b0, 2'b00, 4'd3, 1'b1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    drive_op(1'b1, 2'b01, 4'd2, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1 || out_data !== 64'hF) begin
      n_fail++; $display("FAIL b2b_accept: got rdy=%b d=%h need rdy=1 d=f", in_ready, out_data); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || alu_aluop !== 4'b0001) begin
      n_fail++; $display("FAIL b2b_cmp: got v=%b op=%h need v=0 op=1", out_valid, alu_aluop); end
    @(negedge clk);
    @(negedge clk);
    exp_target = 64'h4020;
    n_checks++; if (br_valid !== 1'b1 || br_taken !== 1'b1 || br_target !== exp_target) begin
      n_fail++; $display("FAIL b2b_branch: got bv=%b tk=%b tgt=%h need 1 1 %h", br_valid, br_taken, br_target, exp_target); end
    @(negedge clk);
  endtask

  task automatic test_branches;
    // BEQ taken
    rs1 = 64'h55; rs2 = 64'h55; pc = 64'h8000_0000; imm = 64'h10;
    run_op(1'b1, 2'b00, 4'd0, 1'b1, 1'b1, 0);
    // BLT not taken (rs1 > rs2)
    rs1 = 64'h100; rs2 = 64'h20; pc = 64'h9000; imm = 64'h40;
    run_op(1'b1, 2'b10, 4'd0, 1'b1, 1'b1, 0);
    // BNE taken
    rs1 = 64'h1; rs2 = 64'h2; pc = 64'hA000; imm = 64'h8;
    run_op(1'b1, 2'b01, 4'd0, 1'b1, 1'b1, 0);
    // BGE taken, signed: rs1 = 0 >= rs2 = -1
    rs1 = 64'h0; rs2 = '1; pc = 64'hB000; imm = 64'hFFFF_FFFF_FFFF_FFF0;
    run_op(1'b1, 2'b11, 4'd0, 1'b1, 1'b1, 0);
  endtask

  task automatic test_flush;
    logic [XLEN-1:0] keep_d;
    // flush during the compare pass of a taken BEQ
    rs1 = 64'h3; rs2 = 64'h3; pc = 64'hC000; imm = 64'h4;
    drive_op(1'b1, 2'b00, 4'd0, 1'b1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b need 0", in_ready); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_checks++; if ({br_valid, br_taken, in_ready, alu_op1_sel, alu_op2_sel} !== 5'b00111) begin
      n_fail++; $display("FAIL flush_brcmp: got bv=%b tk=%b rdy=%b sel=%b%b need 0 0 1 11", br_valid, br_taken, in_ready, alu_op1_sel, alu_op2_sel); end
    @(negedge clk);
    n_checks++; if (br_valid !== 1'b0 || br_target !== exp_target) begin
      n_fail++; $display("FAIL flush_no_pulse: got bv=%b tgt=%h need 0 %h", br_valid, br_target, exp_target); end
    // flush in OUT with out_ready=1 and in_valid=1
    rs1 = 64'h21; rs2 = 64'h3; keep_d = 64'h1E;
    drive_op(1'b0, 2'b00, 4'd1, 1'b1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0 || out_data !== keep_d) begin
      n_fail++; $display("FAIL flush_out_rdy: got rdy=%b d=%h need 0 %h", in_ready, out_data, keep_d); end
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== keep_d || in_ready !== 1'b1 || alu_aluop !== 4'd0) begin
      n_fail++; $display("FAIL flush_out: got v=%b d=%h rdy=%b op=%h need 0 %h 1 0", out_valid, out_data, in_ready, alu_aluop, keep_d); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_late: got %b need 0", out_valid); end
  endtask

  task automatic test_async_reset;
    rs1 = 64'h9; rs2 = 64'h9; pc = 64'hD000; imm = 64'h100;
    drive_op(1'b1, 2'b00, 4'd0, 1'b1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++; if ({out_valid, br_valid, br_taken} !== 3'b000 || out_data !== '0 || br_target !== '0 ||
                    {alu_aluop, alu_op1_sel, alu_op2_sel} !== {4'b0000, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL async_reset: got ov=%b bv=%b tk=%b d=%h tgt=%h ctl=%h/%b/%b need zeros, 0/1/1",
                         out_valid, br_valid, br_taken, out_data, br_target, alu_aluop, alu_op1_sel, alu_op2_sel); end
    exp_target = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (br_valid !== 1'b0) begin n_fail++; $display("FAIL async_no_pulse: got %b need 0", br_valid); end
    rs1 = 64'h40; rs2 = 64'h2;
    run_op(1'b0, 2'b00, 4'd2, 1'b1, 1'b1, 1);
  endtask

  task automatic test_random;
    logic       is_br;
    logic [1:0] bt;
    logic [3:0] aop;
    for (int n = 0; n < 60; n++) begin
      rs1 = {$urandom, $urandom};
      rs2 = ($urandom_range(0, 2) == 0) ? rs1 : {$urandom, $urandom};
      pc  = {$urandom, $urandom};
      imm = {$urandom, $urandom};
      is_br = ($urandom_range(0, 1) == 1);
      bt    = 2'($urandom_range(0, 3));
      aop   = 4'($urandom_range(0, 5));
      run_op(is_br, bt, aop, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3));
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_nonbranch();
    test_backpressure();
    test_back_to_back();
    test_branches();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
